// File: rtl/arc4_sched_if.sv
// Scheduler-facing bundle: host handshake, the three stage handshakes and
// their S-memory requests, and the granted S-memory port.
interface arc4_sched_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              en, rdy, err;
  logic              en_init, en_ksa, en_prga;
  logic              rdy_init, rdy_ksa, rdy_prga;
  logic [ADDR_W-1:0] addr_init, addr_ksa, addr_prga;
  logic [DATA_W-1:0] wrdata_init, wrdata_ksa, wrdata_prga;
  logic              wren_init, wren_ksa, wren_prga;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wrdata;
  logic              s_wren;

  modport master (
    input  en, rdy_init, rdy_ksa, rdy_prga,
           addr_init, addr_ksa, addr_prga,
           wrdata_init, wrdata_ksa, wrdata_prga,
           wren_init, wren_ksa, wren_prga,
    output rdy, err, en_init, en_ksa, en_prga, s_addr, s_wrdata, s_wren
  );

  modport slave (
    output en, rdy_init, rdy_ksa, rdy_prga,
           addr_init, addr_ksa, addr_prga,
           wrdata_init, wrdata_ksa, wrdata_prga,
           wren_init, wren_ksa, wren_prga,
    input  rdy, err, en_init, en_ksa, en_prga, s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/arc4_sched.sv
// ARC4 top sequencer: runs init -> ksa -> prga through rdy/en handshakes and
// grants the single-port S memory to the stage currently in flight.
module arc4_sched #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst_n,
  arc4_sched_if.master bus
);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  // Each stage occupies three consecutive codes so REQ->ACK->RUN->next REQ is +1.
  typedef enum logic [3:0] {
    IDLE,
    REQ_INIT, ACK_INIT, RUN_INIT,
    REQ_KSA,  ACK_KSA,  RUN_KSA,
    REQ_PRGA, ACK_PRGA, RUN_PRGA
  } state_t;

  state_t           state;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       stg;
  logic [3:0]       stg_rdy;
  logic             rdy_x;

  always_comb begin
    stg = 2'd0;
    case (state)
      REQ_KSA, ACK_KSA, RUN_KSA:    stg = 2'd1;
      REQ_PRGA, ACK_PRGA, RUN_PRGA: stg = 2'd2;
      default:                      stg = 2'd0;
    endcase
  end

  assign stg_rdy = {1'b0, bus.rdy_prga, bus.rdy_ksa, bus.rdy_init};
  assign rdy_x   = stg_rdy[stg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.en) begin
          state <= REQ_INIT;
          err_q <= 1'b0;
        end
        REQ_INIT, REQ_KSA, REQ_PRGA: if (rdy_x) begin
          state <= state_t'(state + 4'd1);
          cnt   <= '0;
        end
        // A stage that never drops rdy would otherwise hang the sequence.
        ACK_INIT, ACK_KSA, ACK_PRGA: begin
          if (!rdy_x)
            state <= state_t'(state + 4'd1);
          else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else
            cnt <= cnt + 1'b1;
        end
        RUN_INIT, RUN_KSA: if (rdy_x) state <= state_t'(state + 4'd1);
        RUN_PRGA:          if (rdy_x) state <= IDLE;
        default:           state <= IDLE;
      endcase
    end
  end

  assign bus.rdy     = (state == IDLE);
  assign bus.err     = err_q;
  assign bus.en_init = (state == REQ_INIT) & bus.rdy_init;
  assign bus.en_ksa  = (state == REQ_KSA)  & bus.rdy_ksa;
  assign bus.en_prga = (state == REQ_PRGA) & bus.rdy_prga;

  // Grant follows state only, so ownership switches on the RUN->REQ edge.
  always_comb begin
    bus.s_addr   = '0;
    bus.s_wrdata = '0;
    bus.s_wren   = 1'b0;
    if (state != IDLE) begin
      case (stg)
        2'd1: begin
          bus.s_addr   = bus.addr_ksa;
          bus.s_wrdata = bus.wrdata_ksa;
          bus.s_wren   = bus.wren_ksa;
        end
        2'd2: begin
          bus.s_addr   = bus.addr_prga;
          bus.s_wrdata = bus.wrdata_prga;
          bus.s_wren   = bus.wren_prga;
        end
        default: begin
          bus.s_addr   = bus.addr_init;
          bus.s_wrdata = bus.wrdata_init;
          bus.s_wren   = bus.wren_init;
        end
      endcase
    end
  end
endmodule
